// File: rtl/load_count_if.sv
// Bundle of control, data and observation signals for load_count_unit.
// The bench or the surrounding controller uses the master modport; the
// counter uses the slave modport.
// Optional feature macro: LCU_DOWN_COUNT_EN adds the dir (count direction) signal.
interface load_count_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic             src_sel;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             cnt_en;
    logic             oneshot;
    logic [WIDTH-1:0] limit;
    logic             obs_sel;
`ifdef LCU_DOWN_COUNT_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] obs;
    logic             tc;
    logic             wrap;
    logic             done;
    logic             busy;

    modport master (
        output load, src_sel, data_a, data_b, cnt_en, oneshot, limit, obs_sel,
`ifdef LCU_DOWN_COUNT_EN
        output dir,
`endif
        input  count, obs, tc, wrap, done, busy
    );

    modport slave (
        input  load, src_sel, data_a, data_b, cnt_en, oneshot, limit, obs_sel,
`ifdef LCU_DOWN_COUNT_EN
        input  dir,
`endif
        output count, obs, tc, wrap, done, busy
    );
endinterface

// File: rtl/load_count_unit.sv
// load_count_unit: loadable WIDTH-bit sequencing counter with a programmable
// inclusive limit, free-running wrap or one-shot stop, registered terminal
// count / wrap / done / busy flags and a combinational observation mux.
// Optional feature macro: LCU_DOWN_COUNT_EN (adds bus.dir; dir=1 counts down
// towards 0 and a wrap reloads limit).
module load_count_unit #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic          clk,
    input logic          rst,
    load_count_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] step_val;

    // Source select plus the direction-dependent terminal, reload and step values.
    always_comb begin
        src_val = bus.src_sel ? bus.data_a : bus.data_b;
`ifdef LCU_DOWN_COUNT_EN
        terminal = bus.dir ? '0 : bus.limit;
        reload   = bus.dir ? bus.limit : RESET_VAL;
        step_val = bus.dir ? (count_q - 1'b1) : (count_q + 1'b1);
`else
        terminal = bus.limit;
        reload   = RESET_VAL;
        step_val = count_q + 1'b1;
`endif
    end

    // Next-state logic: load beats a count step; DONE ignores cnt_en.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            count_d = src_val;
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else if (bus.cnt_en && (state_q != ST_DONE)) begin
            state_d = ST_RUN;
            if (count_q != terminal) begin
                count_d = step_val;
            end else if (!bus.oneshot) begin
                count_d = reload;
                wrap_d  = 1'b1;
            end else begin
                state_d = ST_DONE;
            end
        end
        tc_d   = (count_d == terminal);
        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_RUN);
    end

    // State and registered flags; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= RESET_VAL;
            tc_q    <= (RESET_VAL == terminal);
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.count = count_q;
    assign bus.obs   = bus.obs_sel ? count_q : src_val;
    assign bus.tc    = tc_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule
